// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-word load/store bus adapter with byte strobes, timeout and stall
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses trap instead of using lane 0)
module load_store_unit #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        misaligned,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Counter value on the last permitted wait cycle; unused when TIMEOUT is 0.
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       func3_q, func3_d;
   logic [1:0]       off_q, off_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [3:0]       mem_wstrb_q, mem_wstrb_d;
   logic             resp_valid_q, resp_valid_d;
   logic [31:0]      resp_rdata_q, resp_rdata_d;
   logic             resp_err_q, resp_err_d;

   logic             req_legal;
   logic [3:0]       st_wstrb;
   logic [31:0]      st_wdata;

`ifdef LSU_MISALIGN_TRAP_EN
   logic             mis_q, mis_d;
   logic             req_misal;
`endif

   // Extract, sign/zero-extend the addressed lane of a returned bus word.
   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (f3[1:0])
         2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
         default: r = d;
      endcase
      return r;
   endfunction

   // Decode legality, misalignment and store lane formatting of the incoming request.
   always_comb begin
      req_legal = 1'b0;
      st_wstrb  = 4'b0000;
      st_wdata  = req_wdata;
      if (req_write) begin
         req_legal = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010);
      end else begin
         req_legal = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010) ||
                     (req_func3 == 3'b100) || (req_func3 == 3'b101);
      end
      if (req_write) begin
         case (req_func3[1:0])
            2'b00: begin
               st_wstrb = 4'b0001 << req_addr[1:0];
               st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
               st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
               st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
               st_wstrb = 4'b1111;
               st_wdata = req_wdata;
            end
         endcase
      end
`ifdef LSU_MISALIGN_TRAP_EN
      req_misal = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
   end

   // Next-state logic for the IDLE -> BUS -> RESP transaction sequence.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      func3_d      = func3_q;
      off_d        = off_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_d        = mis_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               func3_d = req_func3;
               off_d   = req_addr[1:0];
               if (!req_legal) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
               end else if (req_misal) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
                  mis_d        = 1'b1;
`endif
               end else begin
                  state_d     = S_BUS;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_write;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_wdata_d = st_wdata;
                  mem_wstrb_d = st_wstrb;
               end
            end
         end
         S_BUS: begin
            if (mem_ack) begin
               state_d      = S_RESP;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = mem_we_q ? 32'h0 : fmt_load(func3_q, off_q, mem_rdata);
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               state_d      = S_RESP;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = 32'h0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_d        = 1'b0;
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any outstanding bus cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         func3_q      <= 3'b000;
         off_q        <= 2'b00;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_wstrb_q  <= 4'b0000;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         func3_q      <= func3_d;
         off_q        <= off_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q        <= mis_d;
`endif
      end
   end

   // Core is held while a request is being accepted or a bus cycle is outstanding.
   always_comb begin
      stall = ((state_q == S_IDLE) && req_valid) || (state_q == S_BUS);
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;
`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = mis_q;
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_func3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        misaligned;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_err = 0;
   int req_cycles;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_func3  (req_func3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .misaligned (misaligned),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request in the current (IDLE) cycle, check stall, advance to cycle 1.
   task automatic issue(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      req_valid = 1'b1;
      req_write = wr;
      req_func3 = f3;
      req_addr  = addr;
      req_wdata = wd;
      #1;
      check({tag, "_stall_c0"}, stall, 1);
      tick();
      req_valid = 1'b0;
   endtask

   // Drive the bus until resp_valid; ack after 'waits' wait cycles of mem_req.
   task automatic run_bus(input int waits, input logic [31:0] rd, output int cyc);
      bit got;
      cyc = 0;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         if (resp_valid) begin
            got = 1;
            break;
         end
         if (mem_req) begin
            cyc++;
            if (cyc == waits + 1) begin
               mem_ack   = 1'b1;
               mem_rdata = rd;
            end
         end
         tick();
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
      end
      check("resp_seen", {31'b0, got}, 1);
   endtask

   // Run a load with given wait states and check the formatted result.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input int waits, input logic [31:0] rd, input logic [31:0] exp);
      issue(tag, 1'b0, f3, addr, 32'h0);
      check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
      check({tag, "_wstrb"}, {28'b0, mem_wstrb}, 0);
      check({tag, "_we"}, {31'b0, mem_we}, 0);
      run_bus(waits, rd, req_cycles);
      check({tag, "_reqcyc"}, req_cycles, waits + 1);
      check({tag, "_rdata"}, resp_rdata, exp);
      check({tag, "_err"}, {31'b0, resp_err}, 0);
      check({tag, "_stall_resp"}, {31'b0, stall}, 0);
      tick();
      check({tag, "_pulse"}, {31'b0, resp_valid}, 0);
   endtask

   // Run a store, check bus formatting in cycle 1, ack with no wait states.
   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wd);
      issue(tag, 1'b1, f3, addr, wd);
      check({tag, "_req"}, {31'b0, mem_req}, 1);
      check({tag, "_we"}, {31'b0, mem_we}, 1);
      check({tag, "_addr"}, mem_addr, exp_addr);
      check({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_strb});
      check({tag, "_wdata"}, mem_wdata, exp_wd);
      check({tag, "_stall_c1"}, {31'b0, stall}, 1);
      run_bus(0, 32'h0, req_cycles);
      check({tag, "_reqcyc"}, req_cycles, 1);
      check({tag, "_err"}, {31'b0, resp_err}, 0);
      check({tag, "_rdata"}, resp_rdata, 0);
      check({tag, "_req_resp"}, {31'b0, mem_req}, 0);
      tick();
      check({tag, "_pulse"}, {31'b0, resp_valid}, 0);
   endtask

   // Request with illegal funct3: error response in cycle 1, no bus cycle.
   task automatic do_illegal(input string tag, input logic wr, input logic [2:0] f3);
      issue(tag, wr, f3, 32'h0000_0500, 32'h1234_5678);
      check({tag, "_valid"}, {31'b0, resp_valid}, 1);
      check({tag, "_err"}, {31'b0, resp_err}, 1);
      check({tag, "_req"}, {31'b0, mem_req}, 0);
      check({tag, "_rdata"}, resp_rdata, 0);
      tick();
      check({tag, "_pulse"}, {31'b0, resp_valid}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_func3 = 3'b000;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      tick();
      tick();
      check("rst_req", {31'b0, mem_req}, 0);
      check("rst_valid", {31'b0, resp_valid}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wstrb", {28'b0, mem_wstrb}, 0);
      check("rst_stall", {31'b0, stall}, 0);
      rst = 1'b0;
      tick();

      // SW, zero wait states
      do_store("sw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
      // SH upper half, SB lane 1
      do_store("sh", 3'b001, 32'h0000_0302, 32'h0000_ABCD, 32'h0000_0300, 4'b1100, 32'hABCD_ABCD);
      do_store("sb", 3'b000, 32'h0000_0301, 32'h0000_0055, 32'h0000_0300, 4'b0010, 32'h5555_5555);

      // Loads with 3 wait states
      do_load("lb",  3'b000, 32'h0000_0203, 3, 32'h80FF_1234, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h0000_0203, 3, 32'h80FF_1234, 32'h0000_0080);
      do_load("lh",  3'b001, 32'h0000_0202, 3, 32'h80FF_1234, 32'hFFFF_80FF);
      do_load("lhu", 3'b101, 32'h0000_0200, 0, 32'h80FF_9234, 32'h0000_9234);
      do_load("lw",  3'b010, 32'h0000_0204, 1, 32'h1122_3344, 32'h1122_3344);

      // Timeout with TIMEOUT = 4
      issue("to", 1'b0, 3'b010, 32'h0000_0600, 32'h0);
      run_bus(100, 32'h0, req_cycles);
      check("to_reqcyc", req_cycles, 4);
      check("to_err", {31'b0, resp_err}, 1);
      check("to_rdata", resp_rdata, 0);
      check("to_req", {31'b0, mem_req}, 0);
      tick();
      check("to_pulse", {31'b0, resp_valid}, 0);

      // Illegal funct3
      do_illegal("ill_ld", 1'b0, 3'b011);
      do_illegal("ill_st", 1'b1, 3'b100);

      // Misaligned LW
      issue("mis", 1'b0, 3'b010, 32'h0000_0101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_req", {31'b0, mem_req}, 0);
      check("mis_valid", {31'b0, resp_valid}, 1);
      check("mis_err", {31'b0, resp_err}, 1);
      check("mis_flag", {31'b0, misaligned}, 1);
      check("mis_rdata", resp_rdata, 0);
      tick();
      check("mis_flag_clr", {31'b0, misaligned}, 0);
`else
      check("mis_req", {31'b0, mem_req}, 1);
      check("mis_addr", mem_addr, 32'h0000_0100);
      run_bus(0, 32'hCAFE_F00D, req_cycles);
      check("mis_err", {31'b0, resp_err}, 0);
      check("mis_flag", {31'b0, misaligned}, 0);
      check("mis_rdata", resp_rdata, 32'hCAFE_F00D);
      tick();
`endif

      // Reset in the 2nd BUS cycle, late ack afterwards
      issue("rst", 1'b0, 3'b010, 32'h0000_0400, 32'h0);
      check("rstx_req_c1", {31'b0, mem_req}, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstx_req", {31'b0, mem_req}, 0);
      check("rstx_valid", {31'b0, resp_valid}, 0);
      check("rstx_stall", {31'b0, stall}, 0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack   = 1'b0;
      check("rstx_late_valid", {31'b0, resp_valid}, 0);
      check("rstx_late_req", {31'b0, mem_req}, 0);
      tick();
      check("rstx_late_valid2", {31'b0, resp_valid}, 0);

      // Unit still works after reset
      do_load("post", 3'b000, 32'h0000_0700, 0, 32'h0000_007F, 32'h0000_007F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the datapath's memory outputs (effective address, store data, load/store control) and directly upstream of its load-data input.
- Converts a core load/store request into a single word-aligned data-bus transaction with byte strobes.
- Waits for the bus acknowledge and returns sign- or zero-extended load data.
- Stalls the core while a transaction is outstanding and reports bus timeouts and illegal accesses.

Parameters:
- TIMEOUT, 255: maximum cycles in BUS waiting for mem_ack. 0 disables the timeout.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core requests a memory access this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address (the FU result).
- req_wdata  in  32  store data (the rs2 value).
- stall  out  1  core must hold its request and PC.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  formatted load data (0 for stores and errors).
- resp_err  out  1  qualifies resp_valid: timeout, illegal funct3 or misaligned access.
- misaligned  out  1  qualifies resp_valid: misaligned trap.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address, bits [1:0] = 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables (0000 for loads).
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  bus read data, valid with mem_ack.

Behaviour:
- Reset (sync, active-high) at a clock edge forces the state to IDLE and every output register to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, resp_valid, resp_rdata, resp_err, misaligned, and the wait counter.
- This applies mid-transaction too: an outstanding bus cycle is abandoned and no resp_valid is issued.
- States are IDLE, BUS and RESP.
- IDLE, req_valid = 1 (accept cycle 0):
  - Capture the request.
  - Legal and aligned: load mem_* registers and go to BUS.
  - Illegal funct3 (loads 011/110/111; stores other than 000/001/010): go to RESP with resp_err = 1 and no bus cycle.
- BUS:
  - mem_req = 1 from cycle 1, with mem_addr/mem_we/mem_wdata/mem_wstrb held stable until ack.
  - mem_ack may arrive in the first BUS cycle (zero wait states).
  - On mem_ack: register the formatted load data, clear mem_req, go to RESP.
  - The counter increments for each BUS cycle without ack. When TIMEOUT cycles elapse without ack (TIMEOUT != 0): clear mem_req, go to RESP with resp_err = 1 and rdata = 0.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. Minimum latency is accept cycle 0 to resp_valid cycle 2.
- stall (combinational):
  - 1 in IDLE when req_valid = 1.
  - 1 throughout BUS.
  - 0 in RESP, so the core advances in the response cycle.
  - 0 in IDLE when req_valid = 0.
- req_valid while not in IDLE is ignored. A request in the RESP cycle is a new request, accepted only from IDLE on the next cycle.
- Store formatting, with off = addr[1:0]:
  - SB: wstrb = 1 << off; wdata = byte replicated x4.
  - SH: wstrb = 0011 if addr[1] = 0, else 1100; wdata = half replicated x2.
  - SW: wstrb = 1111, wdata unchanged.
- Load formatting:
  - Select the lane by off (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_addr = {req_addr[31:2], 2'b00} for every access.
- Misalignment: half with addr[0] = 1, or word with addr[1:0] != 0.
- mem_ack outside BUS is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request skips the bus and goes to RESP with resp_err = 1, misaligned = 1, rdata = 0.
- Undefined: the unused low address bits are ignored.
  - SH uses addr[1] only; SW/LW use lane 0.
  - The access proceeds normally.
  - misaligned is tied to 0.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, mem_ack in the first BUS cycle -> cycle 1: mem_req = 1, mem_addr = 0x100, wstrb = 1111, mem_we = 1; cycle 2: resp_valid = 1, resp_err = 0; stall high on cycles 0-1.
- LB addr 0x203, ack after 3 wait cycles with mem_rdata 0x80FF1234 -> resp_rdata = 0xFFFFFF80 and mem_req held 4 cycles; repeat with LBU -> 0x00000080; LH addr 0x202 -> 0xFFFF80FF.
- SH addr 0x302, wdata 0x0000ABCD -> mem_addr = 0x300, wstrb = 1100, mem_wdata = 0xABCDABCD; SB addr 0x301, wdata 0x55 -> wstrb = 0010, mem_wdata = 0x55555555.
- TIMEOUT = 4, mem_ack never asserted -> mem_req high exactly 4 cycles then 0; resp_valid = 1 with resp_err = 1, resp_rdata = 0.
- LW addr 0x101 -> with the macro: no mem_req, resp_err = 1, misaligned = 1 at cycle 1; without it: mem_addr = 0x100, normal completion.
- rst asserted in the 2nd BUS cycle, with a late mem_ack after reset -> next edge mem_req = 0 and state IDLE; no resp_valid; the late ack is ignored.
